// File: rtl/rp_pio_log_pkg.sv
// Shared types for the RP PIO error log capture controller.
// FSM states, log entry bundle and status bit helpers.
package rp_pio_log_pkg;

  localparam int RP_PIO_STATUS_W = 12;
  localparam logic [2:0] LOG_SEL_IMPSPEC = 3'd4;
  localparam int HDR_DW = 4;

  typedef logic [3:0] err_type_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_HDR2,
    ST_HDR3,
    ST_IMP,
    ST_DONE
  } log_fsm_e;

  typedef struct packed {
    err_type_t             err_type;
    logic [HDR_DW*32-1:0]  hdr;
    logic [31:0]           impspec;
  } log_entry_t;

  // Illegal types (12..15) map to no status bit.
  function automatic logic [RP_PIO_STATUS_W-1:0]
    type_onehot(input err_type_t t);
    type_onehot = '0;
    if (t < err_type_t'(RP_PIO_STATUS_W))
      type_onehot[t] = 1'b1;
  endfunction

endpackage

// File: rtl/rp_pio_log_capture_ctrl_arb.sv
// Round-robin arbiter: lowest requester at or after the pointer.
// Pointer moves past the winner when the grant is taken.
module rp_pio_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic               grant_vld
);

  logic [IW-1:0] ptr;

  // Scan requesters starting at the pointer, wrapping.
  always_comb begin
    logic [31:0] j;
    logic        found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (32'(ptr) + 32'(i)) % 32'(NUM_REQ);
      if (!found && req[j[IW-1:0]]) begin
        found               = 1'b1;
        grant[j[IW-1:0]]    = 1'b1;
        grant_idx           = j[IW-1:0];
      end
    end
    grant_vld = |req;
  end

  // Rotate the pointer one past the accepted winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && grant_vld) begin
      if (grant_idx == IW'(NUM_REQ-1))
        ptr <= '0;
      else
        ptr <= grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/rp_pio_log_capture_ctrl.sv
// RP PIO error log capture: arbitrate, write header/impspec log, own status.
// Optional RP_PIO_LOG_OVERFLOW_EN adds overflow_cnt for unlogged reports.
module rp_pio_log_capture_ctrl
  import rp_pio_log_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int RP_PIO_LOG_SIZE = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*4-1:0]       req_err_type,
  input  logic [NUM_REQ*128-1:0]     req_hdr,
  input  logic [NUM_REQ*32-1:0]      req_impspec,
  output logic                       log_wr_en,
  output logic [2:0]                 log_wr_sel,
  output logic [31:0]                log_wr_data,
  input  logic                       sw_clr_en,
  input  logic [RP_PIO_STATUS_W-1:0] sw_clr_mask,
  output logic [RP_PIO_STATUS_W-1:0] status,
  output logic [3:0]                 first_err_ptr,
  output logic                       first_err_vld,
  output logic                       busy
`ifdef RP_PIO_LOG_OVERFLOW_EN
  ,
  output logic [7:0]                 overflow_cnt
`endif
);

  localparam int IW = $clog2(NUM_REQ);
  localparam bit HAS_IMP = (RP_PIO_LOG_SIZE >= 5);

  log_fsm_e     state, state_n;
  log_entry_t   ent_q, ent_n;
  logic         logged_q;
  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0] gidx;
  logic         gvld;
  logic         take;
  logic         wr_en_n;
  logic [2:0]   wr_sel_n;
  logic [31:0]  wr_data_n;
  logic         done;
  logic         ptr_hit;
  logic [RP_PIO_STATUS_W-1:0] clr_v;
  logic [RP_PIO_STATUS_W-1:0] set_v;

  rp_pio_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .advance   (take),
    .grant     (grant),
    .grant_idx (gidx),
    .grant_vld (gvld)
  );

  // Gather the winning requester's report.
  always_comb begin
    ent_n.err_type = req_err_type[32'(gidx)*4 +: 4];
    ent_n.hdr      = req_hdr[32'(gidx)*128 +: 128];
    ent_n.impspec  = req_impspec[32'(gidx)*32 +: 32];
  end

  // Next state, grant pulse and next log write beat.
  always_comb begin
    state_n   = state;
    req_ready = '0;
    take      = 1'b0;
    wr_en_n   = 1'b0;
    wr_sel_n  = 3'd0;
    wr_data_n = 32'd0;
    unique case (state)
      ST_IDLE: begin
        if (gvld && !rst) begin
          req_ready = grant;
          take      = 1'b1;
          if (first_err_vld) begin
            state_n = ST_DONE;
          end else begin
            state_n   = ST_HDR0;
            wr_en_n   = 1'b1;
            wr_data_n = ent_n.hdr[31:0];
          end
        end
      end
      ST_HDR0: begin
        state_n   = ST_HDR1;
        wr_en_n   = 1'b1;
        wr_sel_n  = 3'd1;
        wr_data_n = ent_q.hdr[63:32];
      end
      ST_HDR1: begin
        state_n   = ST_HDR2;
        wr_en_n   = 1'b1;
        wr_sel_n  = 3'd2;
        wr_data_n = ent_q.hdr[95:64];
      end
      ST_HDR2: begin
        state_n   = ST_HDR3;
        wr_en_n   = 1'b1;
        wr_sel_n  = 3'd3;
        wr_data_n = ent_q.hdr[127:96];
      end
      ST_HDR3: begin
        if (HAS_IMP) begin
          state_n   = ST_IMP;
          wr_en_n   = 1'b1;
          wr_sel_n  = LOG_SEL_IMPSPEC;
          wr_data_n = ent_q.impspec;
        end else begin
          state_n = ST_DONE;
        end
      end
      ST_IMP:  state_n = ST_DONE;
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Hold the granted report; logged is decided at grant time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q    <= '0;
      logged_q <= 1'b0;
    end else if (take) begin
      ent_q    <= ent_n;
      logged_q <= ~first_err_vld;
    end
  end

  // Registered log write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      log_wr_en   <= 1'b0;
      log_wr_sel  <= 3'd0;
      log_wr_data <= 32'd0;
    end else begin
      log_wr_en   <= wr_en_n;
      log_wr_sel  <= wr_sel_n;
      log_wr_data <= wr_data_n;
    end
  end

  assign done    = (state == ST_DONE);
  assign clr_v   = sw_clr_en ? sw_clr_mask : '0;
  assign set_v   = done ? type_onehot(ent_q.err_type) : '0;
  assign ptr_hit = sw_clr_en && first_err_vld &&
                   (first_err_ptr < 4'd12) &&
                   sw_clr_mask[first_err_ptr];

  // RW1C status; a same-cycle DONE set beats the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) status <= '0;
    else     status <= (status & ~clr_v) | set_v;
  end

  // First-error pointer: a logged DONE re-arms it over any clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_err_ptr <= 4'd0;
      first_err_vld <= 1'b0;
    end else if (done && logged_q) begin
      first_err_ptr <= ent_q.err_type;
      first_err_vld <= 1'b1;
    end else if (ptr_hit) begin
      first_err_vld <= 1'b0;
    end
  end

`ifdef RP_PIO_LOG_OVERFLOW_EN
  // Count dropped reports; unlocking the log restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_cnt <= 8'd0;
    end else if (ptr_hit) begin
      overflow_cnt <= 8'd0;
    end else if (done && !logged_q &&
                 overflow_cnt != 8'hFF) begin
      overflow_cnt <= overflow_cnt + 8'd1;
    end
  end
`endif

  assign busy = (state != ST_IDLE);

endmodule
